// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register busy/latency scoreboard driving D-stage stall and bypass select.
module hazard_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NSRC = 2,
    parameter int LW   = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 issue_valid,
    input  logic                 issue_we,
    input  logic [AW-1:0]        issue_dst,
    input  logic [LW-1:0]        issue_lat,
    input  logic [NSRC*AW-1:0]   src_addr,
    input  logic [NSRC-1:0]      src_used,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_dst,
    input  logic                 flush,
    output logic                 stall_o,
    output logic [NSRC-1:0]      fwd_hit,
    output logic [31:0]          stall_cycles
);

    logic          busy_q [NREG];
    logic [LW-1:0] cnt_q  [NREG];
    logic          busy_d [NREG];
    logic [LW-1:0] cnt_d  [NREG];

    logic [NSRC-1:0] haz;
    logic            issue_acc;
    logic            wb_acc;

    // Lookups read only registered state, so stall_o has no path from issue_*.
    for (genvar i = 0; i < NSRC; i++) begin : g_slot
        logic [AW-1:0] src;
        logic          live;
        assign src        = src_addr[i*AW +: AW];
        assign live       = src_used[i] && (src != '0) && busy_q[src];
        assign haz[i]     = live && (cnt_q[src] != '0);
        assign fwd_hit[i] = live && (cnt_q[src] == '0);
    end

    assign stall_o   = |haz;
    assign issue_acc = issue_valid && issue_we && !stall_o && (issue_dst != '0) && !flush;
    assign wb_acc    = wb_valid && (wb_dst != '0) && !flush;

    // Priority per entry: flush, then newest issue, then write-back, then countdown.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_d[r] = busy_q[r];
            cnt_d[r]  = cnt_q[r];
            if (flush) begin
                busy_d[r] = 1'b0;
                cnt_d[r]  = '0;
            end else if (issue_acc && (issue_dst == AW'(r))) begin
                busy_d[r] = 1'b1;
                cnt_d[r]  = issue_lat;
            end else if (wb_acc && (wb_dst == AW'(r))) begin
                busy_d[r] = 1'b0;
                cnt_d[r]  = '0;
            end else if (busy_q[r] && (cnt_q[r] != '0)) begin
                cnt_d[r]  = cnt_q[r] - LW'(1);
            end
            if (r == 0) begin
                busy_d[r] = 1'b0;
                cnt_d[r]  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) begin
                busy_q[r] <= 1'b0;
                cnt_q[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                busy_q[r] <= busy_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= '0;
        end else if (stall_o && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - vector table and scoreboard bench for hazard_scoreboard.
module tb_hazard_scoreboard;

    localparam int AW   = 5;
    localparam int LW   = 3;
    localparam int NSRC = 2;
    localparam int NV   = 24;

    logic                clk = 1'b0;
    logic                resetn;
    logic                issue_valid, issue_we, wb_valid, flush;
    logic [AW-1:0]       issue_dst, wb_dst;
    logic [LW-1:0]       issue_lat;
    logic [NSRC*AW-1:0]  src_addr;
    logic [NSRC-1:0]     src_used;
    logic                stall_o;
    logic [NSRC-1:0]     fwd_hit;
    logic [31:0]         stall_cycles;

    typedef struct {
        logic           iv;
        logic           we;
        logic [AW-1:0]  dst;
        logic [LW-1:0]  lat;
        logic [AW-1:0]  s0;
        logic [AW-1:0]  s1;
        logic [1:0]     used;
        logic           wbv;
        logic [AW-1:0]  wbd;
        logic           fl;
        logic           es;
        logic [1:0]     ef;
    } vec_t;

    typedef struct {
        logic        stall;
        logic [1:0]  fwd;
        logic [31:0] sc;
    } exp_t;

    vec_t  vecs [NV];
    exp_t  sb_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic [31:0] sc_model = 0;

    hazard_scoreboard #(.NREG(32), .AW(AW), .NSRC(NSRC), .LW(LW)) dut (
        .clk(clk), .resetn(resetn),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_dst(issue_dst), .issue_lat(issue_lat),
        .src_addr(src_addr), .src_used(src_used),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .flush(flush),
        .stall_o(stall_o), .fwd_hit(fwd_hit), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic iv, input logic we, input int dst, input int lat,
                                input int s0, input int s1, input logic [1:0] used,
                                input logic wbv, input int wbd, input logic fl,
                                input logic es, input logic [1:0] ef);
        vec_t v;
        v.iv = iv; v.we = we; v.dst = AW'(dst); v.lat = LW'(lat);
        v.s0 = AW'(s0); v.s1 = AW'(s1); v.used = used;
        v.wbv = wbv; v.wbd = AW'(wbd); v.fl = fl; v.es = es; v.ef = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        issue_valid = v.iv; issue_we = v.we; issue_dst = v.dst; issue_lat = v.lat;
        src_addr = {v.s1, v.s0}; src_used = v.used;
        wb_valid = v.wbv; wb_dst = v.wbd; flush = v.fl;
        e.stall = v.es; e.fwd = v.ef; e.sc = sc_model;
        sb_q.push_back(e);
    endtask

    task automatic sample(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        check({tag, " stall_o"}, 32'(stall_o), 32'(e.stall));
        check({tag, " fwd_hit"}, 32'(fwd_hit), 32'(e.fwd));
        check({tag, " stall_cycles"}, stall_cycles, e.sc);
        if (e.stall) sc_model++;
    endtask

    initial begin
        vecs[0]  = mk(0,0, 0,0,  8, 0,2'b01, 0,0,0, 0,2'b00);
        vecs[1]  = mk(1,1, 8,0,  0, 0,2'b00, 0,0,0, 0,2'b00);
        vecs[2]  = mk(0,0, 0,0,  8, 0,2'b01, 1,8,0, 0,2'b01);
        vecs[3]  = mk(0,0, 0,0,  8, 0,2'b01, 0,0,0, 0,2'b00);
        vecs[4]  = mk(1,1, 9,2,  0, 0,2'b00, 0,0,0, 0,2'b00);
        vecs[5]  = mk(1,1,10,3,  0, 9,2'b10, 0,0,0, 1,2'b00);
        vecs[6]  = mk(0,0, 0,0, 10, 9,2'b11, 0,0,0, 1,2'b00);
        vecs[7]  = mk(0,0, 0,0, 10, 9,2'b11, 0,0,0, 0,2'b10);
        vecs[8]  = mk(1,1, 5,3,  0, 0,2'b00, 1,5,0, 0,2'b00);
        vecs[9]  = mk(0,0, 0,0,  5, 0,2'b01, 0,0,0, 1,2'b00);
        vecs[10] = mk(0,0, 0,0,  5, 0,2'b01, 0,0,0, 1,2'b00);
        vecs[11] = mk(0,0, 0,0,  5, 0,2'b01, 0,0,0, 1,2'b00);
        vecs[12] = mk(0,0, 0,0,  5, 0,2'b01, 1,5,0, 0,2'b01);
        vecs[13] = mk(1,1, 0,3,  0, 0,2'b00, 0,0,0, 0,2'b00);
        vecs[14] = mk(0,0, 0,0,  0, 0,2'b11, 0,0,0, 0,2'b00);
        vecs[15] = mk(1,1,12,4,  0, 0,2'b00, 0,0,0, 0,2'b00);
        vecs[16] = mk(1,1,13,2, 12, 0,2'b00, 0,0,1, 0,2'b00);
        vecs[17] = mk(0,0, 0,0, 12,13,2'b11, 0,0,0, 0,2'b00);
        vecs[18] = mk(1,1, 3,1,  0, 0,2'b00, 0,0,0, 0,2'b00);
        vecs[19] = mk(0,0, 0,0,  0, 3,2'b10, 0,0,0, 1,2'b00);
        vecs[20] = mk(0,0, 0,0,  0, 3,2'b10, 0,0,0, 0,2'b10);
        vecs[21] = mk(1,0,14,2,  3, 0,2'b00, 0,0,0, 0,2'b00);
        vecs[22] = mk(1,1, 3,2, 14, 0,2'b01, 0,0,0, 0,2'b00);
        vecs[23] = mk(0,0, 0,0,  3,14,2'b11, 0,0,0, 1,2'b00);

        resetn = 1'b0;
        drive(mk(1,1,7,3, 7,8,2'b11, 0,0,0, 0,2'b00));
        #12;
        sample("reset");
        @(negedge clk);
        resetn = 1'b1;

        for (int k = 0; k < NV; k++) begin
            if (k != 0) @(negedge clk);
            drive(vecs[k]);
            #2;
            sample($sformatf("vec%0d", k));
        end

        // Reset in the middle of a countdown: dst 7 with cnt 2 while D reads it.
        @(negedge clk);
        drive(mk(1,1,7,3, 0,0,2'b00, 0,0,0, 0,2'b00));
        #2 sample("arm7");
        @(negedge clk);
        drive(mk(0,0,0,0, 0,0,2'b00, 0,0,0, 0,2'b00));
        #2 sample("idle7");
        @(negedge clk);
        drive(mk(0,0,0,0, 7,0,2'b01, 0,0,0, 1,2'b00));
        #2 sample("read7");
        #1 resetn = 1'b0;
        sc_model = 0;
        drive(mk(0,0,0,0, 7,0,2'b01, 0,0,0, 0,2'b00));
        #1 sample("mid_reset");
        sc_model = 0;
        @(negedge clk);
        resetn = 1'b1;
        drive(mk(1,1,7,1, 7,0,2'b01, 0,0,0, 0,2'b00));
        #2 sample("post_reset");
        @(negedge clk);
        drive(mk(0,0,0,0, 7,0,2'b01, 0,0,0, 1,2'b00));
        #2 sample("first_edge");
        @(negedge clk);
        drive(mk(0,0,0,0, 7,0,2'b01, 0,0,0, 0,2'b01));
        #2 sample("fwd7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: architectural register count; register 0 is hard-wired zero.
REQ-002 Parameter AW, default 5: register address width; NREG SHALL equal 2**AW.
REQ-003 Parameter NSRC, default 2: number of source operands checked per decode cycle.
REQ-004 Parameter LW, default 3: latency counter width; maximum producer latency 2**LW-1.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 resetn  in  1  reset, asynchronous assert, active-low.
REQ-007 issue_valid  in  1  decode-stage instruction leaves D this cycle (valid only when stall_o=0).
REQ-008 issue_we  in  1  issuing instruction writes a GPR.
REQ-009 issue_dst  in  AW  destination register of issuing instruction.
REQ-010 issue_lat  in  LW  cycles after issue+1 before the result is forwardable (ALU=0, load=1, CP0/HI-LO per producer).
REQ-011 src_addr  in  NSRC*AW  packed source registers of the D-stage instruction; slot i at bits [i*AW +: AW].
REQ-012 src_used  in  NSRC  per-slot "operand actually read" flags.
REQ-013 wb_valid  in  1  write-back stage commits a register write.
REQ-014 wb_dst  in  AW  write-back destination.
REQ-015 flush  in  1  pipeline flush (exception/ERET); discards all in-flight producers.
REQ-016 stall_o  out  1  hold D stage and freeze fetch.
REQ-017 fwd_hit  out  NSRC  per slot: operand in flight and forwardable, so the bypass mux selects the network.
REQ-018 stall_cycles  out  32  saturating count of cycles with stall_o=1.

Function
REQ-019 Per register r (1..NREG-1), keep state busy[r] (1 bit) and cnt[r] (LW bits); register 0 SHALL never become busy.
REQ-020 Issue accept: issue_valid & issue_we & !stall_o & issue_dst!=0 sets busy[dst]=1 and cnt[dst]=issue_lat on the next edge.
REQ-021 issue_valid while stall_o=1 SHALL be ignored; it causes no state change.
REQ-022 Every cycle, each busy entry with cnt!=0 and not being re-issued decrements cnt by 1; cnt saturates at 0 and never wraps.
REQ-023 Write-back: wb_valid & wb_dst!=0 clears busy[wb_dst] on the next edge and sets its cnt to 0.
REQ-024 Same-cycle issue and write-back to the same register: issue wins, so busy=1 and cnt=issue_lat (newer producer).
REQ-025 Re-issue to an already busy register SHALL overwrite cnt with the new issue_lat (WAW: youngest producer tracked).
REQ-026 Slot i is hazardous when src_used[i] & src!=0 & busy[src] & cnt[src]!=0.
REQ-027 stall_o SHALL be the combinational OR of all hazardous slots, computed from registered state only, with no combinational path from issue_*.
REQ-028 fwd_hit[i] = src_used[i] & src!=0 & busy[src] & cnt[src]==0, computed combinationally.
REQ-029 fwd_hit and the hazard condition are mutually exclusive per slot; both SHALL be 0 for src=0.
REQ-030 A source matching wb_dst in the current cycle with busy set still reports fwd_hit, because the write-back bypass supplies the value.
REQ-031 flush clears all busy and cnt on the next edge; issue and wb in the same cycle as flush are ignored, so flush has priority.
REQ-032 stall_cycles increments on each edge where stall_o=1 and holds at 32'hFFFF_FFFF.
REQ-033 Latency example: a load issued at edge t with lat=1, followed by a dependent instruction in D at t+1, gives stall_o=1 for exactly 1 cycle, then fwd_hit=1.

Reset
REQ-034 resetn=0 asynchronously clears all busy, cnt and stall_cycles; stall_o=0 and fwd_hit=0 while reset is held.
REQ-035 Reset release: the first functional update occurs on the first rising edge with resetn=1.
REQ-036 Reset asserted mid-countdown SHALL discard all entries with no residual stall.

Verification
REQ-037 Scenario: issue dst=8, lat=0, then D reads src0=8 with src_used=01 -> stall_o=0, fwd_hit=01.
REQ-038 Scenario: issue dst=9, lat=2, then D reads src1=9 -> stall_o=1 for 2 cycles, then fwd_hit=10; stall_cycles=2.
REQ-039 Scenario: same-cycle issue dst=5 lat=3 and wb_dst=5 -> next cycle busy[5]=1, reading 5 stalls 3 cycles.
REQ-040 Scenario: issue dst=0 lat=3, then read src0=0 -> stall_o=0, fwd_hit=0.
REQ-041 Scenario: issue dst=12 lat=4, flush after 1 cycle -> next cycle reading 12 gives stall_o=0, fwd_hit=0.
REQ-042 Scenario: resetn pulsed low mid-countdown with dst=7 cnt=2 -> stall_o=0 immediately and stall_cycles=0.
